// File: rtl/downscaler_pkg.sv
// downscaler_pkg: shared widths, reciprocal table and mode type for the downscaler
package downscaler_pkg;
  typedef enum logic {DS_SUB, DS_AVG} ds_mode_t;
  function automatic int ds_fact_w(input int max_fact);
    return $clog2(max_fact + 1);
  endfunction
  function automatic int ds_sum_w(input int width, input int max_fact);
    return width + $clog2(max_fact * max_fact);
  endfunction
  function automatic int ds_sh(input int sum_w);
    return 2 * sum_w;
  endfunction
  // ceil(2^sh / n): a rounding-up reciprocal keeps the round-half-up result exact
  function automatic logic [63:0] ds_recip(input int n, input int sh);
    return ((64'd1 << sh) + 64'(n) - 64'd1) / 64'(n);
  endfunction
endpackage

// File: rtl/ds_line_acc.sv
// ds_line_acc: simple dual-port line accumulator RAM with registered read
module ds_line_acc #(
  parameter int DEPTH = 1920,
  parameter int DW = 42,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  // write and read columns never coincide, so no bypass is needed
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/downscaler_nx.sv
// downscaler_nx: integer-factor video downscaler, sub-sample or rounded box average
module downscaler_nx import downscaler_pkg::*; #(
  parameter int WIDTH = 10,
  parameter int NCH = 3,
  parameter int HACT = 1920,
  parameter int MAX_FACT = 4,
  localparam int FACT_W = ds_fact_w(MAX_FACT)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [FACT_W-1:0]    i_h_fact,
  input  logic [FACT_W-1:0]    i_v_fact,
  input  logic                 i_avg,
  input  logic                 i_vsync,
  input  logic                 i_hsync,
  input  logic                 i_de,
  input  logic [NCH*WIDTH-1:0] i_data,
  output logic                 o_vsync,
  output logic                 o_hsync,
  output logic                 o_de,
  output logic [NCH*WIDTH-1:0] o_data,
  output logic                 o_cfg_err
);
  localparam int SUM_W = ds_sum_w(WIDTH, MAX_FACT);
  localparam int SH = ds_sh(SUM_W);
  localparam int RW = SH + 1;
  localparam int PW = SUM_W + RW;
  localparam int AW = $clog2(HACT);
  localparam int NMAX = MAX_FACT * MAX_FACT;
  localparam int NW = $clog2(NMAX + 1);
  logic [FACT_W-1:0] hf, vf, hcnt, vcnt, cur_h, hn, vn;
  ds_mode_t mode;
  logic [NW-1:0] n;
  logic cfg_err, run, de_d, vs_rise, de_rise, de_fall, h_ok, v_ok, hend, done, vlast;
  logic [2:0] vs_d, hs_d;
  logic [AW-1:0] kcnt, cur_k, s1_col;
  logic [NCH-1:0][WIDTH-1:0] pix, first_px, cur_first, s1_pix, s2_pix, res;
  logic [NCH-1:0][SUM_W-1:0] hacc, cur_sum, s1_sum, s2_sum, rd, wd;
  logic [NCH-1:0][PW-1:0] prod;
  logic [RW-1:0] recip_tab [0:NMAX];
  logic s1_v, s1_out, s1_vfirst, s2_v;
  assign pix = i_data;
  assign vs_rise = i_vsync & ~vs_d[0];
  assign de_rise = i_de & ~de_d;
  assign de_fall = ~i_de & de_d;
  assign h_ok = i_h_fact != '0 && i_h_fact <= FACT_W'(MAX_FACT);
  assign v_ok = i_v_fact != '0 && i_v_fact <= FACT_W'(MAX_FACT);
  assign hn = h_ok ? i_h_fact : FACT_W'(1);
  assign vn = v_ok ? i_v_fact : FACT_W'(1);
  assign cur_h = de_rise ? '0 : hcnt;
  assign cur_k = de_rise ? '0 : kcnt;
  assign hend = cur_h == hf - FACT_W'(1);
  assign done = i_de & run & hend;
  assign vlast = vcnt == vf - FACT_W'(1);
  assign cur_first = cur_h == '0 ? pix : first_px;
  assign o_vsync = vs_d[2];
  assign o_hsync = hs_d[2];
  assign o_cfg_err = cfg_err;
  for (genvar g = 0; g <= NMAX; g++) begin : g_rc
    assign recip_tab[g] = RW'(ds_recip(g == 0 ? 1 : g, SH));
  end
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign cur_sum[c] = (cur_h == '0 ? '0 : hacc[c]) + SUM_W'(pix[c]);
    assign wd[c] = s1_vfirst ? s1_sum[c] : rd[c] + s1_sum[c];
    assign prod[c] = PW'(s2_sum[c]) * PW'(recip_tab[n]) + (PW'(1) << (SH - 1));
    assign res[c] = WIDTH'(prod[c] >> SH);
  end
  ds_line_acc #(.DEPTH(HACT), .DW(NCH * SUM_W)) u_acc (
    .clk(clk), .we(s1_v & (mode == DS_AVG)), .waddr(s1_col), .wdata(wd), .raddr(cur_k), .rdata(rd)
  );
  // sync delay lines, frame-start config latch and horizontal/vertical counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_d <= '0;
      hs_d <= '0;
      de_d <= 1'b0;
      hf <= FACT_W'(1);
      vf <= FACT_W'(1);
      mode <= DS_SUB;
      n <= NW'(1);
      cfg_err <= 1'b0;
      run <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
      kcnt <= '0;
      hacc <= '0;
      first_px <= '0;
    end else begin
      vs_d <= {vs_d[1:0], i_vsync};
      hs_d <= {hs_d[1:0], i_hsync};
      de_d <= i_de;
      if (vs_rise) begin
        hf <= hn;
        vf <= vn;
        mode <= ds_mode_t'(i_avg);
        n <= NW'(hn) * NW'(vn);
        cfg_err <= ~(h_ok & v_ok);
        run <= 1'b1;
      end
      if (i_de) begin
        hcnt <= hend ? '0 : cur_h + FACT_W'(1);
        kcnt <= cur_k + AW'(hend);
        hacc <= cur_sum;
        first_px <= cur_first;
      end
      if (vs_rise) vcnt <= '0;
      else if (de_fall) vcnt <= vlast ? '0 : vcnt + FACT_W'(1);
    end
  end
  // three-stage datapath: group complete, vertical accumulate, scale and register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v <= 1'b0;
      s1_out <= 1'b0;
      s1_vfirst <= 1'b0;
      s1_col <= '0;
      s1_sum <= '0;
      s1_pix <= '0;
      s2_v <= 1'b0;
      s2_sum <= '0;
      s2_pix <= '0;
      o_de <= 1'b0;
      o_data <= '0;
    end else begin
      s1_v <= done;
      s1_out <= done & (mode == DS_AVG ? vlast : vcnt == '0);
      s1_vfirst <= vcnt == '0;
      s1_col <= cur_k;
      s1_sum <= cur_sum;
      s1_pix <= cur_first;
      s2_v <= s1_out;
      s2_sum <= wd;
      s2_pix <= s1_pix;
      o_de <= s2_v;
      if (s2_v) o_data <= mode == DS_AVG ? res : s2_pix;
    end
  end
endmodule
